// File: rtl/fetch_pc_unit.sv
// Fetch PC generator: issues aligned fetch-block requests, tracks them in an
// in-flight FIFO and squashes responses made stale by a redirect.
module fetch_pc_unit #(
  parameter int          FETCH_W  = 4,
  parameter int          INFLIGHT = 4,
  parameter int          N_REDIR  = 2,
  parameter logic [31:0] RESET_PC = 32'h1eceb000,
  localparam int         CW       = $clog2(FETCH_W) + 1,
  localparam int         IW       = $clog2(INFLIGHT) + 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REDIR-1:0]        redir_valid,
  input  logic [N_REDIR-1:0][31:0]  redir_pc,
  input  logic [N_REDIR-1:0][63:0]  redir_order,
  input  logic                      stall,
  output logic                      req_valid,
  output logic [31:0]               req_addr,
  input  logic                      req_ready,
  input  logic                      resp_valid,
  output logic                      out_valid,
  output logic [31:0]               out_pc,
  output logic [63:0]               out_order,
  output logic [CW-1:0]             out_count,
  output logic [IW-1:0]             inflight_cnt
);
  localparam int OFFW = CW - 1;
  localparam int ALW  = OFFW + 2;
  localparam int PW   = IW - 1;

  typedef struct packed {
    logic [31:0]   pc;
    logic [63:0]   order;
    logic [CW-1:0] count;
  } ent_t;

  logic [31:0]         pc_q;
  logic [63:0]         order_q;
  ent_t                mem [INFLIGHT];
  logic [INFLIGHT-1:0] stale_q;
  logic [PW-1:0]       wptr, rptr;
  logic [IW-1:0]       cnt_q;

  logic [CW-1:0] off, count;
  logic [31:0]   pc_seq;
  logic          full, empty, push, pop;
  logic          redir_any;
  logic [31:0]   redir_tgt;
  logic [63:0]   redir_ord;
  ent_t          head;

  // Slot offset of pc inside its block; a 1-wide block has no offset bits.
  generate
    if (OFFW > 0) begin : g_off
      assign off = {1'b0, pc_q[ALW-1:2]};
    end else begin : g_off_none
      assign off = '0;
    end
  endgenerate

  assign count    = CW'(FETCH_W) - off;
  assign req_addr = {pc_q[31:ALW], {ALW{1'b0}}};
  assign pc_seq   = req_addr + 32'(FETCH_W * 4);

  assign full      = (cnt_q == IW'(INFLIGHT));
  assign empty     = (cnt_q == '0);
  assign req_valid = !rst && !stall && !full;
  assign push      = req_valid && req_ready;
  assign pop       = !rst && resp_valid && !empty;

  // Scan high-to-low so the lowest-indexed asserted channel wins.
  always_comb begin
    redir_any = 1'b0;
    redir_tgt = '0;
    redir_ord = '0;
    for (int k = N_REDIR - 1; k >= 0; k--) begin
      if (redir_valid[k]) begin
        redir_any = 1'b1;
        redir_tgt = redir_pc[k];
        redir_ord = redir_order[k];
      end
    end
  end

  assign head         = mem[rptr];
  assign out_valid    = pop && !stale_q[rptr] && !redir_any;
  assign out_pc       = head.pc;
  assign out_order    = head.order;
  assign out_count    = head.count;
  assign inflight_cnt = cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      order_q <= '0;
      wptr    <= '0;
      rptr    <= '0;
      cnt_q   <= '0;
      stale_q <= '0;
    end else begin
      if (redir_any) begin
        pc_q    <= redir_tgt;
        order_q <= redir_ord + 64'd1;
      end else if (push) begin
        pc_q    <= pc_seq;
        order_q <= order_q + 64'(count);
      end
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      cnt_q <= cnt_q + IW'(push) - IW'(pop);
      // A request accepted alongside a redirect is already on the wrong path.
      if (redir_any) stale_q <= '1;
      if (push)      stale_q[wptr] <= redir_any;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= '{pc: pc_q, order: order_q, count: count};
  end

  resp_on_empty: assert property (@(posedge clk) disable iff (rst) !(resp_valid && empty));

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Bench for fetch_pc_unit: scoreboard of issued blocks plus a redirect vector table.
module tb_fetch_pc_unit;
  localparam int          FW  = 4;
  localparam int          INF = 4;
  localparam int          NR  = 2;
  localparam logic [31:0] RPC = 32'h1eceb000;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NR-1:0]        redir_valid;
  logic [NR-1:0][31:0]  redir_pc;
  logic [NR-1:0][63:0]  redir_order;
  logic                 stall, req_valid, req_ready, resp_valid, out_valid;
  logic [31:0]          req_addr, out_pc;
  logic [63:0]          out_order;
  logic [2:0]           out_count;
  logic [2:0]           inflight_cnt;

  fetch_pc_unit #(.FETCH_W(FW), .INFLIGHT(INF), .N_REDIR(NR), .RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst), .redir_valid(redir_valid), .redir_pc(redir_pc),
    .redir_order(redir_order), .stall(stall), .req_valid(req_valid),
    .req_addr(req_addr), .req_ready(req_ready), .resp_valid(resp_valid),
    .out_valid(out_valid), .out_pc(out_pc), .out_order(out_order),
    .out_count(out_count), .inflight_cnt(inflight_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] pc;
    logic [63:0] order;
    int          cnt;
    bit          stale;
  } ent_t;
  ent_t        mq[$];
  logic [31:0] mpc;
  logic [63:0] mord;

  typedef struct {
    logic [1:0]  rv;
    logic [31:0] pc0;
    logic [63:0] o0;
    logic [31:0] pc1;
    logic [63:0] o1;
    logic [31:0] addr;
    logic [31:0] opc;
    logic [63:0] oord;
    logic [2:0]  ocnt;
    logic [31:0] nxt_addr;
    logic [63:0] nxt_ord;
  } vec_t;
  vec_t tbl[5];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idle();
    redir_valid = '0;
    req_ready   = 1'b0;
    resp_valid  = 1'b0;
    stall       = 1'b0;
  endtask

  // One clock: check outputs against the model, advance the model, cross the edge.
  task automatic step();
    bit          pop, push, rv, any;
    ent_t        h;
    int          k, acnt;
    logic [31:0] aaddr;
    #1;
    aaddr = {mpc[31:4], 4'h0};
    acnt  = FW - int'(mpc[3:2]);
    any   = |redir_valid;
    rv    = !rst && !stall && (mq.size() < INF);
    chk("req_valid", req_valid, rv);
    if (rst) begin
      chk("out_valid_in_rst", out_valid, 0);
      mpc  = RPC;
      mord = '0;
      mq.delete();
    end else begin
      if (rv) chk("req_addr", req_addr, aaddr);
      chk("inflight_cnt", inflight_cnt, mq.size());
      pop = resp_valid && (mq.size() > 0);
      if (pop) begin
        h = mq.pop_front();
        chk("out_valid", out_valid, !h.stale && !any);
        if (!h.stale && !any) begin
          chk("out_pc", out_pc, h.pc);
          chk("out_order", out_order, h.order);
          chk("out_count", out_count, h.cnt);
        end
      end else begin
        chk("out_valid_idle", out_valid, 0);
      end
      push = rv && req_ready;
      if (any) foreach (mq[i]) mq[i].stale = 1'b1;
      if (push) mq.push_back('{pc: mpc, order: mord, cnt: acnt, stale: any});
      if (any) begin
        k    = redir_valid[0] ? 0 : 1;
        mpc  = redir_pc[k];
        mord = redir_order[k] + 64'd1;
      end else if (push) begin
        mpc  = aaddr + 32'(FW * 4);
        mord = mord + 64'(acnt);
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    idle();
    redir_pc    = '0;
    redir_order = '0;
    mpc  = RPC;
    mord = '0;
    tbl[0] = '{2'b01, 32'h1eceb008, 64'd99, 32'h0, 64'd0,
               32'h1eceb000, 32'h1eceb008, 64'd100, 3'd2, 32'h1eceb010, 64'd102};
    tbl[1] = '{2'b11, 32'h100, 64'd5, 32'h200, 64'd50,
               32'h100, 32'h100, 64'd6, 3'd4, 32'h110, 64'd10};
    tbl[2] = '{2'b10, 32'h0, 64'd0, 32'h20c, 64'd7,
               32'h200, 32'h20c, 64'd8, 3'd1, 32'h210, 64'd9};
    tbl[3] = '{2'b01, 32'hfffffff0, 64'hffff_ffff_ffff_fffd, 32'h0, 64'd0,
               32'hfffffff0, 32'hfffffff0, 64'hffff_ffff_ffff_fffe, 3'd4, 32'h0, 64'd2};
    tbl[4] = '{2'b11, 32'h4, 64'hffff_ffff_ffff_ffff, 32'h300, 64'd1,
               32'h0, 32'h4, 64'd0, 3'd3, 32'h10, 64'd3};
    @(negedge clk);
    step();
    step();
    rst = 1'b0;
    #1 chk("rst_addr", req_addr, RPC);
    chk("rst_inflight", inflight_cnt, 0);

    // Sequential stream, response two cycles after the first request
    req_ready = 1'b1;
    #1 chk("seq_a0", req_addr, 32'h1eceb000);
    step();
    #1 chk("seq_a1", req_addr, 32'h1eceb010);
    step();
    resp_valid = 1'b1;
    #1 chk("seq_a2", req_addr, 32'h1eceb020);
    chk("seq_o0", out_order, 64'd0);
    step();
    req_ready = 1'b0;
    #1 chk("seq_o1", out_order, 64'd4);
    step();
    #1 chk("seq_o2", out_order, 64'd8);
    chk("seq_cnt", out_count, 3'd4);
    step();
    resp_valid = 1'b0;
    step();

    // Redirect vectors: redirect, issue target block, receive it, then the next block
    for (int i = 0; i < 5; i++) begin
      redir_valid    = tbl[i].rv;
      redir_pc[0]    = tbl[i].pc0;
      redir_order[0] = tbl[i].o0;
      redir_pc[1]    = tbl[i].pc1;
      redir_order[1] = tbl[i].o1;
      step();
      redir_valid = '0;
      req_ready   = 1'b1;
      #1 chk("tbl_addr", req_addr, tbl[i].addr);
      step();
      req_ready  = 1'b0;
      resp_valid = 1'b1;
      #1 chk("tbl_out_valid", out_valid, 1'b1);
      chk("tbl_out_pc", out_pc, tbl[i].opc);
      chk("tbl_out_order", out_order, tbl[i].oord);
      chk("tbl_out_count", out_count, tbl[i].ocnt);
      step();
      resp_valid = 1'b0;
      req_ready  = 1'b1;
      #1 chk("tbl_nxt_addr", req_addr, tbl[i].nxt_addr);
      step();
      req_ready  = 1'b0;
      resp_valid = 1'b1;
      #1 chk("tbl_nxt_order", out_order, tbl[i].nxt_ord);
      step();
      resp_valid = 1'b0;
    end

    // Fill to capacity, then one response frees a slot
    req_ready = 1'b1;
    repeat (4) step();
    #1 chk("full_cnt", inflight_cnt, 3'd4);
    chk("full_req_valid", req_valid, 1'b0);
    resp_valid = 1'b1;
    step();
    #1 chk("after_pop_req_valid", req_valid, 1'b1);
    req_ready = 1'b0;
    repeat (3) step();
    resp_valid = 1'b0;

    // Stall blocks requests
    stall     = 1'b1;
    req_ready = 1'b1;
    #1 chk("stall_req_valid", req_valid, 1'b0);
    step();
    stall = 1'b0;

    // Three in flight, redirect, stale responses are squashed
    repeat (3) step();
    req_ready      = 1'b0;
    redir_valid    = 2'b01;
    redir_pc[0]    = 32'h5000;
    redir_order[0] = 64'd20;
    step();
    redir_valid = '0;
    resp_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 chk("squash", out_valid, 1'b0);
      step();
    end
    resp_valid = 1'b0;
    req_ready  = 1'b1;
    step();
    req_ready  = 1'b0;
    resp_valid = 1'b1;
    #1 chk("post_redir_valid", out_valid, 1'b1);
    chk("post_redir_pc", out_pc, 32'h5000);
    step();
    resp_valid = 1'b0;

    // Redirect and handshake in the same cycle push a stale entry
    req_ready      = 1'b1;
    redir_valid    = 2'b01;
    redir_pc[0]    = 32'h6004;
    redir_order[0] = 64'd0;
    step();
    redir_valid = '0;
    req_ready   = 1'b0;
    resp_valid  = 1'b1;
    #1 chk("stale_push", out_valid, 1'b0);
    step();
    resp_valid = 1'b0;

    // Redirect coinciding with a fresh head response drops it
    req_ready = 1'b1;
    step();
    req_ready      = 1'b0;
    resp_valid     = 1'b1;
    redir_valid    = 2'b10;
    redir_pc[1]    = 32'h7000;
    redir_order[1] = 64'd3;
    #1 chk("redir_drop", out_valid, 1'b0);
    step();
    redir_valid = '0;
    resp_valid  = 1'b0;

    // Reset mid-stream, with a response in the reset cycle
    req_ready = 1'b1;
    repeat (2) step();
    rst        = 1'b1;
    resp_valid = 1'b1;
    step();
    rst        = 1'b0;
    resp_valid = 1'b0;
    req_ready  = 1'b0;
    #1 chk("midrst_cnt", inflight_cnt, 3'd0);
    chk("midrst_addr", req_addr, RPC);
    chk("midrst_req_valid", req_valid, 1'b1);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
